// File: rtl/calc_pkg.sv
// Shared calculator types: FSM states, seven-segment patterns,
// and a constant helper for counter sizing.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Active-low patterns, written a..g from left to right
   localparam logic [0:6] SEG_BLANK = 7'b1111111;
   localparam logic [0:6] SEG_0     = 7'b0000001;
   localparam logic [0:6] SEG_1     = 7'b1001111;
   localparam logic [0:6] SEG_2     = 7'b0010010;
   localparam logic [0:6] SEG_3     = 7'b0000110;
   localparam logic [0:6] SEG_4     = 7'b1001100;
   localparam logic [0:6] SEG_5     = 7'b0100100;
   localparam logic [0:6] SEG_6     = 7'b0100000;
   localparam logic [0:6] SEG_7     = 7'b0001111;
   localparam logic [0:6] SEG_8     = 7'b0000000;
   localparam logic [0:6] SEG_9     = 7'b0000100;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r = r + 1;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/seven_seg_digit.sv
// One BCD digit to active-low seven-segment pattern,
// with forced blanking for leading zeros.
module seven_seg_digit
   import calc_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [0:6] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/result_display_encoder.sv
// Sequential double-dabble converter from a signed calculator value
// to sign + BCD, driving three digit displays and a minus segment.
module result_display_encoder
   import calc_pkg::*;
#(
   parameter int N      = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [N-1:0]          value,
   output logic                  busy,
   output logic                  done,
   output logic                  sign,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [0:6]            HEX0,
   output logic [0:6]            HEX1,
   output logic [0:6]            HEX2,
   output logic                  HEX3_g
);

   localparam int W  = 4*DIGITS + N;
   localparam int CW = clog2(N);

   state_t              state;
   logic [N-1:0]        val_q;
   logic                neg_q;
   logic [W-1:0]        sr;
   logic [CW-1:0]       cnt;
   logic [W-1:0]        adj;
   logic [W-1:0]        sr_nxt;
   logic [4*DIGITS-1:0] fin;
   logic                blank1;
   logic                blank2;
   logic [0:6]          seg0;
   logic [0:6]          seg1;
   logic [0:6]          seg2;

   always_comb begin
      adj = sr;
      for (int i = 0; i < DIGITS; i++)
         if (sr[N+4*i +: 4] >= 4'd5)
            adj[N+4*i +: 4] = sr[N+4*i +: 4] + 4'd3;
      sr_nxt = adj << 1;
   end

   // Outputs are loaded from the last shift, so they are valid in DONE
   assign fin    = sr_nxt[W-1 -: 4*DIGITS];
   assign blank2 = (fin[8 +: 4] == 4'd0);
   assign blank1 = blank2 && (fin[4 +: 4] == 4'd0);

   seven_seg_digit u_d0 (.bcd(fin[0 +: 4]), .blank(1'b0),   .seg(seg0));
   seven_seg_digit u_d1 (.bcd(fin[4 +: 4]), .blank(blank1), .seg(seg1));
   seven_seg_digit u_d2 (.bcd(fin[8 +: 4]), .blank(blank2), .seg(seg2));

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state  <= IDLE;
         val_q  <= '0;
         neg_q  <= 1'b0;
         sr     <= '0;
         cnt    <= '0;
         sign   <= 1'b0;
         bcd    <= '0;
         HEX0   <= SEG_0;
         HEX1   <= SEG_BLANK;
         HEX2   <= SEG_BLANK;
         HEX3_g <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  val_q <= value;
                  state <= LOAD;
               end
            end
            LOAD: begin
               neg_q <= val_q[N-1];
               sr    <= {{(4*DIGITS){1'b0}},
                         (val_q[N-1] ? -val_q : val_q)};
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               sr  <= sr_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N-1)) begin
                  bcd    <= fin;
                  sign   <= neg_q;
                  HEX0   <= seg0;
                  HEX1   <= seg1;
                  HEX2   <= seg2;
                  HEX3_g <= ~(neg_q & (fin != '0));
                  state  <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_display_encoder.sv
// Randomized and directed checks of the BCD display encoder
// against an arithmetic decimal reference model.
module tb_result_display_encoder;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [7:0]  value;
   logic        busy;
   logic        done;
   logic        sign;
   logic [11:0] bcd;
   logic [0:6]  HEX0;
   logic [0:6]  HEX1;
   logic [0:6]  HEX2;
   logic        HEX3_g;

   int n_chk;
   int n_pass;

   logic [6:0] segs [10];
   localparam logic [6:0] BLANK = 7'b1111111;

   result_display_encoder #(.N(8), .DIGITS(3)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .value(value), .busy(busy), .done(done), .sign(sign),
      .bcd(bcd), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
      .HEX3_g(HEX3_g)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic check_model(input string tag, input logic [7:0] v);
      int s, mag, u, t, h;
      logic [6:0] e0, e1, e2;
      s   = $signed(v);
      mag = (s < 0) ? -s : s;
      u   = mag % 10;
      t   = (mag / 10) % 10;
      h   = mag / 100;
      e0  = segs[u];
      e1  = (h == 0 && t == 0) ? BLANK : segs[t];
      e2  = (h == 0) ? BLANK : segs[h];
      chk({tag, ".bcd"}, 32'(bcd), 32'(h*256 + t*16 + u));
      chk({tag, ".sign"}, 32'(sign), 32'(s < 0));
      chk({tag, ".hex0"}, 32'(HEX0), 32'(e0));
      chk({tag, ".hex1"}, 32'(HEX1), 32'(e1));
      chk({tag, ".hex2"}, 32'(HEX2), 32'(e2));
      chk({tag, ".hex3"}, 32'(HEX3_g), 32'(!(s < 0 && mag != 0)));
   endtask

   // Called at a negedge; returns at the negedge after the done cycle
   task automatic do_conv(input string tag, input logic [7:0] v);
      int n;
      start = 1'b1;
      value = v;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      value = $urandom;
      n = 1;
      while (!done && n < 30) begin
         @(negedge clock);
         n++;
      end
      chk({tag, ".lat"}, 32'(n), 32'd10);
      check_model(tag, v);
      @(negedge clock);
      chk({tag, ".dw"}, 32'(done), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".done"}, 32'(done), 32'd0);
      chk({tag, ".bcd"}, 32'(bcd), 32'd0);
      chk({tag, ".sign"}, 32'(sign), 32'd0);
      chk({tag, ".hex0"}, 32'(HEX0), 32'(7'b0000001));
      chk({tag, ".hex1"}, 32'(HEX1), 32'(BLANK));
      chk({tag, ".hex2"}, 32'(HEX2), 32'(BLANK));
      chk({tag, ".hex3"}, 32'(HEX3_g), 32'd1);
   endtask

   initial begin
      int gap, seen;
      n_chk  = 0;
      n_pass = 0;
      segs = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
               7'b0000000, 7'b0000100};
      reset_n = 1'b0;
      start   = 1'b0;
      value   = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset("rst");
      reset_n = 1'b1;

      do_conv("p123", 8'd123);
      do_conv("n128", 8'h80);
      do_conv("nm1", 8'hFF);
      do_conv("zero", 8'd0);
      do_conv("d7", 8'd7);
      do_conv("d40", 8'd40);
      do_conv("p127", 8'd127);

      for (int i = 0; i < 40; i++)
         do_conv("rnd", 8'($urandom));

      // Start held high: value changes while busy must not be captured
      start = 1'b1;
      value = 8'd55;
      @(posedge clock);
      @(negedge clock);
      value = 8'd99;
      seen = 0;
      gap  = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) begin
            if (seen == 0) check_model("hold1", 8'd55);
            else chk("hold.gap", 32'(gap), 32'd11);
            seen++;
            gap = 0;
         end
         gap++;
         @(negedge clock);
         if (seen == 1) value = 8'd99;
      end
      chk("hold.cnt", 32'(seen >= 3), 32'd1);
      check_model("hold2", 8'd99);
      start = 1'b0;
      repeat (12) @(negedge clock);

      // Abort during SHIFT iteration 4
      start = 1'b1;
      value = 8'd200;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         if (done) seen++;
         @(negedge clock);
      end
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("abort.nodone", 32'(seen + int'(done)), 32'd0);
      check_reset("abort");
      reset_n = 1'b1;
      do_conv("post", 8'hC3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
